// File: rtl/conv_accum_requant.sv
// Accumulates TERMS signed products plus bias per output pixel, then rounds, saturates
// and optionally ReLU-clamps the sum into a one-entry valid/ready output register.
module conv_accum_requant #(
   parameter int BITS  = 17,
   parameter int NFRAC = 8,
   parameter int TERMS = 9,
   parameter int BIAS  = 0,
   parameter int RELU  = 0
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        clear,
   input  logic signed [2*BITS-1:0]    prod_in,
   input  logic                        prod_valid,
   output logic                        prod_ready,
   output logic signed [BITS-1:0]      out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        sat_flag
);

   localparam int ACC_BITS = 2*BITS + $clog2(TERMS) + 1;
   localparam int CNT_BITS = (TERMS > 1) ? $clog2(TERMS) : 1;

   localparam logic signed [BITS-1:0]     BIAS_V   = BITS'(BIAS);
   localparam logic signed [ACC_BITS-1:0] ACC_INIT = ACC_BITS'(BIAS_V) <<< NFRAC;
   localparam logic signed [ACC_BITS-1:0] SAT_MAX  =
      {{(ACC_BITS-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
   localparam logic signed [ACC_BITS-1:0] SAT_MIN  =
      {{(ACC_BITS-BITS+1){1'b1}}, {(BITS-1){1'b0}}};
   localparam logic [CNT_BITS-1:0]        CNT_LAST = CNT_BITS'(TERMS-1);

   logic [CNT_BITS-1:0]        cnt_q;
   logic signed [ACC_BITS-1:0] acc_q;
   logic signed [ACC_BITS-1:0] prod_ext;
   logic signed [ACC_BITS-1:0] sum;
   logic signed [ACC_BITS-1:0] r;
   logic signed [BITS-1:0]     res;
   logic                       sat;
   logic                       last;
   logic                       accept;

   assign last       = (cnt_q == CNT_LAST);
   // Only the final term has to wait for the output register to free up.
   assign prod_ready = !clear && !(last && out_valid && !out_ready);
   assign accept     = prod_valid && prod_ready;
   assign prod_ext   = ACC_BITS'(prod_in);
   assign sum        = acc_q + prod_ext;

   if (NFRAC > 0) begin : g_round
      localparam logic signed [ACC_BITS-1:0] HALF = ACC_BITS'(1) <<< (NFRAC-1);
      assign r = (sum + HALF) >>> NFRAC;
   end else begin : g_no_round
      assign r = sum;
   end

   always_comb begin
      sat = 1'b0;
      res = r[BITS-1:0];
      if (r > SAT_MAX) begin
         res = {1'b0, {(BITS-1){1'b1}}};
         sat = 1'b1;
      end else if (r < SAT_MIN) begin
         res = {1'b1, {(BITS-1){1'b0}}};
         sat = 1'b1;
      end
      if (RELU != 0 && res[BITS-1]) begin
         res = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         acc_q <= ACC_INIT;
      end else if (clear) begin
         cnt_q <= '0;
         acc_q <= ACC_INIT;
      end else if (accept) begin
         if (last) begin
            cnt_q <= '0;
            acc_q <= ACC_INIT;
         end else begin
            cnt_q <= cnt_q + CNT_BITS'(1);
            acc_q <= sum;
         end
      end
   end

   // A final accept wins over a drain, so a simultaneous drain+load leaves no bubble.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= 1'b0;
      end else if (accept && last) begin
         out_valid <= 1'b1;
         out_data  <= res;
         sat_flag  <= sat;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_accum_requant.sv
// Scoreboard bench: three instances (plain, BIAS=256, RELU=1) share one stimulus stream and
// are checked against an independent integer model of round/saturate/ReLU.
module tb_conv_accum_requant;

   localparam int BITS = 17;

   typedef struct packed {
      logic [17:0] e0;
      logic [17:0] e1;
      logic [17:0] e2;
   } exp_t;

   logic                     clk = 1'b0;
   logic                     reset_n = 1'b0;
   logic                     clear = 1'b0;
   logic signed [2*BITS-1:0] prod_in = '0;
   logic                     prod_valid = 1'b0;
   logic                     out_ready = 1'b1;

   logic              ready0, ready1, ready2;
   logic [BITS-1:0]   data0, data1, data2;
   logic              valid0, valid1, valid2;
   logic              sat0, sat1, sat2;

   int     errors = 0;
   int     checks = 0;
   exp_t   q[$];
   longint sum_acc = 0;
   int     tc = 0;

   always #5 clk = ~clk;

   conv_accum_requant #(.BITS(17), .NFRAC(8), .TERMS(9), .BIAS(0), .RELU(0)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .prod_in(prod_in),
      .prod_valid(prod_valid), .prod_ready(ready0), .out_data(data0), .out_valid(valid0),
      .out_ready(out_ready), .sat_flag(sat0));

   conv_accum_requant #(.BITS(17), .NFRAC(8), .TERMS(9), .BIAS(256), .RELU(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .clear(clear), .prod_in(prod_in),
      .prod_valid(prod_valid), .prod_ready(ready1), .out_data(data1), .out_valid(valid1),
      .out_ready(out_ready), .sat_flag(sat1));

   conv_accum_requant #(.BITS(17), .NFRAC(8), .TERMS(9), .BIAS(0), .RELU(1)) dut_r (
      .clk(clk), .reset_n(reset_n), .clear(clear), .prod_in(prod_in),
      .prod_valid(prod_valid), .prod_ready(ready2), .out_data(data2), .out_valid(valid2),
      .out_ready(out_ready), .sat_flag(sat2));

   function automatic logic [17:0] model(input longint psum, input longint bias, input bit relu);
      longint s;
      longint rr;
      logic   sat;
      sat = 1'b0;
      s   = psum + bias * 256;
      rr  = (s + 128) >>> 8;
      if (rr > 65535) begin
         rr  = 65535;
         sat = 1'b1;
      end else if (rr < -65536) begin
         rr  = -65536;
         sat = 1'b1;
      end
      if (relu && rr < 0) rr = 0;
      return {sat, rr[16:0]};
   endfunction

   task automatic account(input logic signed [2*BITS-1:0] v);
      exp_t e;
      sum_acc += longint'(v);
      tc++;
      if (tc == 9) begin
         e.e0 = model(sum_acc, 0, 1'b0);
         e.e1 = model(sum_acc, 256, 1'b0);
         e.e2 = model(sum_acc, 0, 1'b1);
         q.push_back(e);
         sum_acc = 0;
         tc = 0;
      end
   endtask

   // Presents one term, waits (bounded) for acceptance; leaves prod_valid high.
   task automatic send_term(input logic signed [2*BITS-1:0] v);
      int n;
      prod_in    = v;
      prod_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (ready0) break;
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL send_term_timeout: prod_ready stuck at %b, required 1", ready0);
            prod_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      account(v);
   endtask

   task automatic idle(input int n);
      prod_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({valid0, data0, sat0} !== 19'd0) begin
         errors++;
         $display("FAIL reset_out: got v=%b d=%h s=%b, required 0/0/0", valid0, data0, sat0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (ready0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b, required 1", ready0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) send_term(34'sd65536);
      checks++;
      if (valid0 !== 1'b0) begin
         errors++;
         $display("FAIL basic_early_valid: got %b, required 0", valid0);
      end
      send_term(34'sd65536);
      checks++;
      if (valid0 !== 1'b1 || data0 !== 17'd2304) begin
         errors++;
         $display("FAIL basic_latency: got v=%b d=%0d, required v=1 d=2304", valid0, data0);
      end
      idle(2);
   endtask

   task automatic test_rounding();
      for (int i = 0; i < 8; i++) send_term('0);
      send_term(34'sd384);
      for (int i = 0; i < 8; i++) send_term('0);
      send_term(-34'sd384);
      for (int i = 0; i < 9; i++) send_term('0);
      idle(2);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 9; i++) send_term(34'sd16777216);
      for (int i = 0; i < 9; i++) send_term(-34'sd16777216);
      idle(2);
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) send_term(34'sd65536);
      for (int i = 0; i < 8; i++) send_term(34'sd131072);
      prod_in    = 34'sd131072;
      prod_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (ready0 !== 1'b0 || valid0 !== 1'b1 || data0 !== 17'd2304) begin
            errors++;
            $display("FAIL stall_hold: got rdy=%b v=%b d=%0d, required rdy=0 v=1 d=2304",
                     ready0, valid0, data0);
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (ready0 !== 1'b1) begin
         errors++;
         $display("FAIL drain_ready: got %b, required 1", ready0);
      end
      @(posedge clk);
      #1;
      account(34'sd131072);
      prod_valid = 1'b0;
      checks++;
      if (valid0 !== 1'b1 || data0 !== 17'd4608) begin
         errors++;
         $display("FAIL no_bubble: got v=%b d=%0d, required v=1 d=4608", valid0, data0);
      end
      idle(2);
   endtask

   task automatic test_clear();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_term(34'sd65536);
      clear      = 1'b1;
      prod_in    = 34'sd65536;
      prod_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (ready0 !== 1'b0) begin
         errors++;
         $display("FAIL clear_ready: got %b, required 0", ready0);
      end
      @(posedge clk);
      #1;
      clear      = 1'b0;
      prod_valid = 1'b0;
      sum_acc    = 0;
      tc         = 0;
      for (int i = 0; i < 9; i++) send_term(34'sd65536);
      idle(2);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int i = 0; i < 9; i++) send_term(34'sd65536);
      for (int i = 0; i < 5; i++) send_term(34'sd65536);
      prod_valid = 1'b0;
      reset_n    = 1'b0;
      #1;
      checks++;
      if (valid0 !== 1'b0 || data0 !== 17'd0 || valid1 !== 1'b0 || data1 !== 17'd0) begin
         errors++;
         $display("FAIL reset_mid: got v=%b d=%0d vb=%b db=%0d, required all 0",
                  valid0, data0, valid1, data1);
      end
      q.delete();
      sum_acc = 0;
      tc      = 0;
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 9; i++) send_term(34'sd65536);
      idle(2);
   endtask

   // Scoreboard pop on every output handshake.
   always @(negedge clk) begin
      if (reset_n && valid0 && out_ready) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got d=%0d with empty scoreboard, required none",
                     $signed(data0));
         end else begin
            exp_t e;
            e = q.pop_front();
            if ({sat0, data0} !== e.e0 || {sat1, data1} !== e.e1 || {sat2, data2} !== e.e2
                || valid1 !== 1'b1 || valid2 !== 1'b1) begin
               errors++;
               $display("FAIL scoreboard: got %h/%h/%h, required %h/%h/%h",
                        {sat0, data0}, {sat1, data1}, {sat2, data2}, e.e0, e.e1, e.e2);
            end
         end
      end
   end

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_empty: got %0d pending, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv_accum_requant.md
Name: conv_accum_requant

Overview:
- Sits directly downstream of the per-tap shift-add/multiplier stages in the 2D convolution datapath.
- Consumes a stream of signed full-width products (Q.2*NFRAC) and sums TERMS of them per output pixel, with a bias added.
- Rounds the sum back to Q.NFRAC, saturates it to BITS, and optionally applies ReLU.
- Presents the result on a valid/ready output with a one-entry output register, so backpressure is absorbed.

Parameters:
- BITS, 17, data width of output; products are 2*BITS wide.
- NFRAC, 8, fractional bits of data/weights; products carry 2*NFRAC fractional bits.
- TERMS, 9, products per output pixel (kernel taps); must be >= 1.
- BIAS, 0, signed BITS-wide bias in Q.NFRAC.
- RELU, 0, 1 = clamp negative results to 0.
- ACC_BITS, 2*BITS+$clog2(TERMS)+1, accumulator width (derived, not overridden).

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort of the current partial sum.
- prod_in  input  2*BITS  signed product, Q.2*NFRAC.
- prod_valid  input  1  prod_in valid.
- prod_ready  output  1  block accepts prod_in this cycle.
- out_data  output  BITS  signed result, Q.NFRAC.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- sat_flag  output  1  result saturated; qualified by out_valid.

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-low: clk, reset_n.
- Reset values:
  - cnt=0.
  - acc=BIAS sign-extended then << NFRAC (denoted ACC_INIT).
  - out_valid=0, out_data=0, sat_flag=0.
- Accept:
  - A term is accepted when prod_valid && prod_ready.
  - prod_in is sign-extended to ACC_BITS and added to acc.
  - cnt increments, wrapping TERMS-1 -> 0.
- Final term (accept while cnt==TERMS-1):
  - sum = acc + prod_in.
  - acc reloads ACC_INIT and cnt=0 in the same cycle.
  - sum goes to requantize.
- Requantize (combinational on sum):
  - NFRAC>0: r = (sum + 2^(NFRAC-1)) >>> NFRAC, i.e. round half toward +inf. NFRAC=0: r=sum.
  - Saturate r to [-2^(BITS-1), 2^(BITS-1)-1]; sat=1 if clamped.
  - If RELU=1 and the saturated value < 0, result=0. sat is still reported.
- Output register:
  - Loaded on a final-term accept; out_valid=1 the next cycle (latency 1 cycle from final accept).
  - Holds data and sat_flag stable while out_valid && !out_ready.
  - Cleared (out_valid=0) on out_valid && out_ready with no simultaneous load.
- Ready:
  - prod_ready = !clear && !(cnt==TERMS-1 && out_valid && !out_ready).
  - Non-final terms of the next pixel are accepted while the output is stalled; only the final term stalls.
- Simultaneous drain and load (out_valid && out_ready and final accept in the same cycle): register reloads, out_valid stays 1, no bubble.
- clear:
  - cnt=0, acc=ACC_INIT; prod_ready is 0 that cycle, so no product is consumed.
  - The output register and out_valid are unaffected.
- TERMS=1: every accept is final, and acc stays at ACC_INIT.
- reset_n asserted mid-pixel or mid-stall: partial sum and pending output are discarded immediately.
- No overflow of acc is possible for any input, given ACC_BITS.

Test Plan (BITS=17, NFRAC=8, TERMS=9, BIAS=0, RELU=0 unless stated):
1. Nine accepts of prod_in=65536 (1.0*1.0) -> out_data=2304 (9.0), sat_flag=0. out_valid is high exactly 1 cycle after the 9th accept.
2. Rounding, eight terms 0 plus one term 384 -> out_data=2; repeat with -384 -> out_data=-1 (0x1FFFF). BIAS=256 with nine zero terms -> out_data=256.
3. Saturation:
   - Nine terms of 2^24 -> out_data=65535, sat_flag=1.
   - Nine terms of -2^24 -> out_data=-65536 (0x10000), sat_flag=1.
   - With RELU=1, the negative case -> out_data=0, sat_flag=1.
4. Backpressure, out_ready=0:
   - Pixel 1 completes, and all 8 non-final terms of pixel 2 are accepted.
   - prod_ready=0 at the 9th term, and out_data holds pixel 1.
   - When out_ready=1, pixel 1 drains and the 9th term is accepted in the same cycle.
   - Pixel 2 appears next cycle with out_valid continuously high.
5. clear after 4 accepted terms of 65536, then nine terms of 65536 -> out_data=2304. A prod_valid pulse coincident with clear is not accepted (prod_ready=0).
6. Assert reset_n low while out_valid=1 and cnt=5 -> out_valid=0, out_data=0 immediately. Nine fresh terms of 65536 after release -> 2304.
